// File: rtl/seg_display_ctrl_pkg.sv
// Shared state encoding and 7-segment lookup for the display controller.
// Segment codes are active-high {g,f,e,d,c,b,a}; polarity is applied by the user.
package seg_display_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_STORE  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [3:0] BCD_NINE  = 4'd9;

  function automatic logic [6:0] seg_lut(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = 7'h3F;
      4'h1:    code = 7'h06;
      4'h2:    code = 7'h5B;
      4'h3:    code = 7'h4F;
      4'h4:    code = 7'h66;
      4'h5:    code = 7'h6D;
      4'h6:    code = 7'h7D;
      4'h7:    code = 7'h07;
      4'h8:    code = 7'h7F;
      4'h9:    code = 7'h6F;
      4'hA:    code = 7'h77;
      4'hB:    code = 7'h7C;
      4'hC:    code = 7'h39;
      4'hD:    code = 7'h5E;
      4'hE:    code = 7'h79;
      default: code = 7'h71;
    endcase
    return code;
  endfunction

  function automatic logic [6:0] seg_drive(input logic [3:0] nib, input logic blank,
                                           input logic active_low);
    logic [6:0] raw;
    raw = blank ? SEG_BLANK : seg_lut(nib);
    return active_low ? ~raw : raw;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_dabble_engine.sv
// Iterative shift-add-3 binary-to-BCD converter, one input bit per step, MSB first.
// ovf_out is sticky: any carry out of the top BCD nibble during the conversion sets it.
module dabble_engine #(
  parameter int IN_WIDTH = 6,
  parameter int DIGITS   = 2
) (
  input  logic                  clk,
  input  logic                  load,
  input  logic                  step,
  input  logic [IN_WIDTH-1:0]   bin_in,
  output logic [DIGITS*4-1:0]   bcd_out,
  output logic                  ovf_out
);

  localparam int BCD_W = DIGITS * 4;

  logic [BCD_W-1:0]    bcd_q, bcd_d, adj;
  logic [IN_WIDTH-1:0] bin_q, bin_d;
  logic                sticky_q, sticky_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    bcd_d    = bcd_q;
    bin_d    = bin_q;
    sticky_d = sticky_q;
    if (load) begin
      bcd_d    = '0;
      bin_d    = bin_in;
      sticky_d = 1'b0;
    end else if (step) begin
      bcd_d    = {adj[BCD_W-2:0], bin_q[IN_WIDTH-1]};
      bin_d    = bin_q << 1;
      sticky_d = sticky_q | adj[BCD_W-1];
    end
  end

  always_ff @(posedge clk) begin
    bcd_q    <= bcd_d;
    bin_q    <= bin_d;
    sticky_q <= sticky_d;
  end

  assign bcd_out = bcd_q;
  assign ovf_out = sticky_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// Multi-channel binary-to-7-segment controller: snapshot, convert each channel in turn,
// then swap the whole display in one edge so the pins never show a half-finished update.
module seg_display_ctrl
  import seg_display_ctrl_pkg::*;
#(
  parameter int IN_WIDTH       = 6,
  parameter int CHANNELS       = 2,
  parameter int DIGITS         = 2,
  parameter int BLANK_LZ       = 0,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AUTO           = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           hex_mode,
  input  logic [CHANNELS*IN_WIDTH-1:0]   values,
  output logic                           busy,
  output logic                           done,
  output logic [CHANNELS-1:0]            ovf,
  output logic [CHANNELS*DIGITS*7-1:0]   seg
);

  localparam int VAL_W = CHANNELS * IN_WIDTH;
  localparam int BCD_W = DIGITS * 4;
  localparam int SEG_W = CHANNELS * DIGITS * 7;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);
  localparam int HEX_W = (IN_WIDTH > BCD_W) ? IN_WIDTH : BCD_W;

  localparam logic [6:0]       BLANK_CODE = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
  localparam logic [SEG_W-1:0] SEG_RST    = {(CHANNELS*DIGITS){BLANK_CODE}};

  state_e                 state_q, state_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [CNT_W-1:0]       bitcnt_q, bitcnt_d;
  logic [VAL_W-1:0]       snap_q, snap_d;
  logic                   hex_q, hex_d;
  logic [CHANNELS*BCD_W-1:0] shadow_dig_q, shadow_dig_d;
  logic [CHANNELS-1:0]    shadow_ovf_q, shadow_ovf_d;
  logic [SEG_W-1:0]       seg_q, seg_d;
  logic [CHANNELS-1:0]    ovf_q, ovf_d;
  logic                   done_q, done_d;

  logic                   go;
  logic                   eng_load, eng_step, eng_ovf;
  logic [IN_WIDTH-1:0]    eng_bin, cur_val, next_val;
  logic [BCD_W-1:0]       eng_bcd;

  function automatic logic [BCD_W-1:0] all_nines();
    logic [BCD_W-1:0] r;
    for (int d = 0; d < DIGITS; d++) r[4*d +: 4] = BCD_NINE;
    return r;
  endfunction

  function automatic logic [BCD_W-1:0] hex_digits(input logic [IN_WIDTH-1:0] v);
    logic [HEX_W-1:0] ext;
    ext = HEX_W'(v);
    return ext[BCD_W-1:0];
  endfunction

  // Only widths wider than the digit field can lose bits in hex mode.
  function automatic logic hex_over(input logic [IN_WIDTH-1:0] v);
    logic [HEX_W-1:0] ext;
    logic             ov;
    ext = HEX_W'(v);
    ov  = 1'b0;
    for (int i = BCD_W; i < HEX_W; i++) ov = ov | ext[i];
    return ov;
  endfunction

  function automatic logic [SEG_W-1:0] encode_all(input logic [CHANNELS*BCD_W-1:0] dig,
                                                  input logic [CHANNELS-1:0] ch_ovf);
    logic [SEG_W-1:0] r;
    logic [3:0]       nib;
    logic             lead, blank;
    r = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      lead = 1'b1;
      for (int d = DIGITS - 1; d >= 0; d--) begin
        nib   = dig[(k*DIGITS + d)*4 +: 4];
        lead  = lead && (nib == 4'd0);
        blank = (BLANK_LZ != 0) && !ch_ovf[k] && (d > 0) && lead;
        r[(k*DIGITS + d)*7 +: 7] = seg_drive(nib, blank, SEG_ACTIVE_LOW != 0);
      end
    end
    return r;
  endfunction

  dabble_engine #(
    .IN_WIDTH (IN_WIDTH),
    .DIGITS   (DIGITS)
  ) u_engine (
    .clk     (clk),
    .load    (eng_load),
    .step    (eng_step),
    .bin_in  (eng_bin),
    .bcd_out (eng_bcd),
    .ovf_out (eng_ovf)
  );

  assign go = start || (AUTO != 0);

  always_comb begin
    cur_val  = snap_q[IN_WIDTH-1:0];
    next_val = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch_q == CH_W'(k)) cur_val = snap_q[k*IN_WIDTH +: IN_WIDTH];
    end
    for (int k = 1; k < CHANNELS; k++) begin
      if (ch_q == CH_W'(k - 1)) next_val = snap_q[k*IN_WIDTH +: IN_WIDTH];
    end
  end

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    bitcnt_d     = bitcnt_q;
    snap_d       = snap_q;
    hex_d        = hex_q;
    shadow_dig_d = shadow_dig_q;
    shadow_ovf_d = shadow_ovf_q;
    seg_d        = seg_q;
    ovf_d        = ovf_q;
    done_d       = 1'b0;
    eng_load     = 1'b0;
    eng_step     = 1'b0;
    eng_bin      = next_val;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          snap_d   = values;
          hex_d    = hex_mode;
          ch_d     = '0;
          bitcnt_d = CNT_W'(IN_WIDTH);
          eng_load = 1'b1;
          eng_bin  = values[IN_WIDTH-1:0];
          state_d  = ST_SHIFT;
        end
      end
      // Hex mode still walks all IN_WIDTH steps so latency is mode-independent.
      ST_SHIFT: begin
        eng_step = 1'b1;
        bitcnt_d = bitcnt_q - 1'b1;
        if (bitcnt_q == CNT_W'(1)) state_d = ST_STORE;
      end
      ST_STORE: begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (ch_q == CH_W'(k)) begin
            if (hex_q) begin
              shadow_dig_d[k*BCD_W +: BCD_W] = hex_digits(cur_val);
              shadow_ovf_d[k]                = hex_over(cur_val);
            end else begin
              shadow_dig_d[k*BCD_W +: BCD_W] = eng_ovf ? all_nines() : eng_bcd;
              shadow_ovf_d[k]                = eng_ovf;
            end
          end
        end
        if (ch_q == CH_W'(CHANNELS - 1)) begin
          state_d = ST_COMMIT;
        end else begin
          ch_d     = ch_q + 1'b1;
          bitcnt_d = CNT_W'(IN_WIDTH);
          eng_load = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_COMMIT: begin
        seg_d   = encode_all(shadow_dig_q, shadow_ovf_q);
        ovf_d   = shadow_ovf_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      bitcnt_q <= '0;
      seg_q    <= SEG_RST;
      ovf_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      bitcnt_q <= bitcnt_d;
      seg_q    <= seg_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  // Snapshot and shadow are always rewritten before the next commit reads them.
  always_ff @(posedge clk) begin
    snap_q       <= snap_d;
    hex_q        <= hex_d;
    shadow_dig_q <= shadow_dig_d;
    shadow_ovf_q <= shadow_ovf_d;
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign ovf  = ovf_q;
  assign seg  = seg_q;

endmodule
